ins_fetcher: RTL
================

INS_FETCHER -- requirements
Module: ins_fetcher

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h0, first fetch address after reset.
REQ-002 SHALL have port clk_in  input  1  the one clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port rdy_in  input  1  global ready; low freezes all state.
REQ-005 SHALL have port mem_req_valid  output  1  fetch request pulse to instruction memory.
REQ-006 SHALL have port mem_req_addr  output  32  word-aligned fetch address.
REQ-007 SHALL have port mem_resp_valid  input  1  instruction word returned.
REQ-008 SHALL have port mem_resp_data  input  32  returned instruction word.
REQ-009 SHALL have port ins_ready  output  1  ins/pc/predict_nxt_pc valid to decoder.
REQ-010 SHALL have port ins  output  32  instruction word.
REQ-011 SHALL have port pc  output  32  {fetch address[31:1], predicted-taken bit}.
REQ-012 SHALL have port predict_nxt_pc  output  32  predicted next fetch address.
REQ-013 SHALL have port IFetcher_stall  input  1  decoder cannot accept; hold outputs.
REQ-014 SHALL have port IFetcher_clear  input  1  decoder redirect (JALR target known).
REQ-015 SHALL have port IFetcher_new_addr  input  32  redirect target for IFetcher_clear.
REQ-016 SHALL have port rob_flush  input  1  mispredict flush from ROB.
REQ-017 SHALL have port rob_flush_addr  input  32  correct restart address.

Function
REQ-018 SHALL implement states IDLE, WAIT, HOLD, BLOCK plus a 1-bit drop flag.
REQ-019 IDLE: SHALL drive mem_req_valid=1 for exactly one cycle with mem_req_addr={fetch_pc[31:2],2'b00}, then enter WAIT.
REQ-020 WAIT, mem_resp_valid=1, drop=0: SHALL latch ins=mem_resp_data, pc, predict_nxt_pc, set ins_ready=1, enter HOLD.
REQ-021 Prediction: JAL -> fetch_pc+immJ; B-type -> per REQ-033; JALR -> fetch_pc+4 with BLOCK pending; all others -> fetch_pc+4; sums modulo 2^32.
REQ-022 pc[0] SHALL be 1 only for a B-type predicted taken.
REQ-023 HOLD: at an edge with IFetcher_stall=0 the instruction is consumed: ins_ready<=0, fetch_pc<=predict_nxt_pc, next IDLE (BLOCK if JALR); with IFetcher_stall=1 all outputs SHALL hold stable.
REQ-024 BLOCK: no requests; on IFetcher_clear=1, fetch_pc<=IFetcher_new_addr, next IDLE.
REQ-025 rob_flush=1 in any state SHALL set fetch_pc<=rob_flush_addr, ins_ready<=0; next IDLE, except from WAIT without response that edge: stay WAIT with drop=1.
REQ-026 IFetcher_clear outside BLOCK SHALL act as REQ-025 with IFetcher_new_addr; rob_flush has priority when both high.
REQ-027 WAIT, mem_resp_valid=1, drop=1: SHALL discard data, clear drop, enter IDLE; latency from redirect to next request thus >=1 cycle after the outstanding response.
REQ-028 Redirect target bits [1:0] SHALL be ignored (forced 00).
REQ-029 rdy_in=0: no register updates; mem_req_valid held; memory is frozen by the same rdy_in.
REQ-030 At most one memory request outstanding at any time.

Reset
REQ-031 rst_in low SHALL immediately set state=IDLE, drop=0, fetch_pc=RESET_PC, ins_ready=0, ins=0, pc=0, predict_nxt_pc=0, mem_req_valid=0, mem_req_addr=0.
REQ-032 First request SHALL issue on the first rdy_in=1 edge after rst_in returns high; reset mid-WAIT discards the outstanding response state.

Configuration
REQ-033 BRANCH_PREDICT_EN defined: B-type with negative immB predicted taken (fetch_pc+immB, pc[0]=1), positive not taken; undefined: every B-type not taken (fetch_pc+4, pc[0]=0).

Verification
REQ-034 Reset, RESET_PC=0, memory returns 32'h00500093 after 1 cycle -> request addr 0, ins_ready=1, pc=0, predict_nxt_pc=4.
REQ-035 HOLD with IFetcher_stall=1 for 3 cycles -> ins/pc unchanged, no new request; stall low -> next request addr 4.
REQ-036 Fetch at 0x100 of beq offset -8 -> with BRANCH_PREDICT_EN pc=0x101, predict_nxt_pc=0xF8; without pc=0x100, predict_nxt_pc=0x104.
REQ-037 jalr consumed at 0x20 -> BLOCK, no requests; IFetcher_clear with IFetcher_new_addr=0x84 -> next request addr 0x84.
REQ-038 rob_flush addr 0x200 while WAIT -> outstanding response discarded, ins_ready stays 0, next request addr 0x200.
REQ-039 rob_flush and IFetcher_clear same edge, addrs 0x300/0x400 -> next request addr 0x300.

Source files
------------

// File: rtl/ins_fetcher_if.sv
// ins_fetcher_if: signal bundle between the instruction fetcher, the
// instruction memory and the decoder/ROB redirect sources.
interface ins_fetcher_if;
  // Handshakes: mem_req_valid is a one-cycle request pulse with no back-pressure,
  // and memory answers each request with exactly one mem_resp_valid pulse.
  // ins_ready keeps ins/pc/predict_nxt_pc stable until an edge with
  // IFetcher_stall low consumes them. All of it advances only while rdy_in is high.
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        ins_ready;
  logic [31:0] ins;
  logic [31:0] pc;
  logic [31:0] predict_nxt_pc;
  logic        IFetcher_stall;
  logic        IFetcher_clear;
  logic [31:0] IFetcher_new_addr;
  logic        rob_flush;
  logic [31:0] rob_flush_addr;

  modport master (
    output mem_req_valid, mem_req_addr, ins_ready, ins, pc, predict_nxt_pc,
    input  mem_resp_valid, mem_resp_data, IFetcher_stall, IFetcher_clear,
    input  IFetcher_new_addr, rob_flush, rob_flush_addr
  );

  modport slave (
    input  mem_req_valid, mem_req_addr, ins_ready, ins, pc, predict_nxt_pc,
    output mem_resp_valid, mem_resp_data, IFetcher_stall, IFetcher_clear,
    output IFetcher_new_addr, rob_flush, rob_flush_addr
  );
endinterface

// File: rtl/ins_fetcher.sv
// ins_fetcher: single-outstanding instruction fetcher with static next-PC
// prediction. Define BRANCH_PREDICT_EN to predict backward branches taken.
module ins_fetcher #(
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic          clk_in,
  input  logic          rst_in,
  input  logic          rdy_in,
  ins_fetcher_if.master bus,
  output logic [2:0]    dbg_state
);

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    BLOCK = 2'd3
  } state_t;

  state_t      state;
  logic        drop;
  logic        jalr_pend;
  logic [31:0] fetch_pc;

  logic [31:0] rdata;
  logic [6:0]  opcode;
  logic        is_jal;
  logic        is_jalr;
  logic        br_taken;
  logic [31:0] imm_j;
  logic [31:0] br_target;
  logic [31:0] pred_pc;
  logic        redirect;
  logic [31:0] redir_pc;

  assign rdata   = bus.mem_resp_data;
  assign opcode  = rdata[6:0];
  assign is_jal  = (opcode == OP_JAL);
  assign is_jalr = (opcode == OP_JALR);
  assign imm_j   = {{12{rdata[31]}}, rdata[19:12], rdata[20], rdata[30:21], 1'b0};

`ifdef BRANCH_PREDICT_EN
  logic [31:0] imm_b;
  assign imm_b     = {{20{rdata[31]}}, rdata[7], rdata[30:25], rdata[11:8], 1'b0};
  assign br_taken  = (opcode == OP_BRANCH) && rdata[31];
  assign br_target = fetch_pc + imm_b;
`else
  assign br_taken  = 1'b0;
  assign br_target = fetch_pc + 32'd4;
`endif

  // JALR targets are unknown here: fall through and block until the decoder redirects.
  always_comb begin
    pred_pc = fetch_pc + 32'd4;
    if (is_jal)        pred_pc = fetch_pc + imm_j;
    else if (br_taken) pred_pc = br_target;
  end

  // ROB flush outranks a decoder redirect; targets are always word aligned.
  assign redirect  = bus.rob_flush | bus.IFetcher_clear;
  assign redir_pc  = (bus.rob_flush ? bus.rob_flush_addr : bus.IFetcher_new_addr)
                     & 32'hFFFF_FFFC;
  assign dbg_state = {drop, state};

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state              <= IDLE;
      drop               <= 1'b0;
      jalr_pend          <= 1'b0;
      fetch_pc           <= RESET_PC;
      bus.mem_req_valid  <= 1'b0;
      bus.mem_req_addr   <= 32'd0;
      bus.ins_ready      <= 1'b0;
      bus.ins            <= 32'd0;
      bus.pc             <= 32'd0;
      bus.predict_nxt_pc <= 32'd0;
    end else if (rdy_in) begin
      case (state)
        IDLE: begin
          if (redirect) begin
            fetch_pc <= redir_pc;
          end else begin
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_addr  <= fetch_pc & 32'hFFFF_FFFC;
            state             <= WAIT;
          end
        end
        WAIT: begin
          bus.mem_req_valid <= 1'b0;
          if (bus.mem_resp_valid) begin
            drop <= 1'b0;
            if (redirect) begin
              fetch_pc <= redir_pc;
              state    <= IDLE;
            end else if (drop) begin
              state <= IDLE;
            end else begin
              bus.ins            <= rdata;
              bus.pc             <= (fetch_pc & 32'hFFFF_FFFE) | {31'd0, br_taken};
              bus.predict_nxt_pc <= pred_pc;
              bus.ins_ready      <= 1'b1;
              jalr_pend          <= is_jalr;
              state              <= HOLD;
            end
          end else if (redirect) begin
            // The request is already out; remember to throw its answer away.
            fetch_pc <= redir_pc;
            drop     <= 1'b1;
          end
        end
        HOLD: begin
          if (redirect) begin
            fetch_pc      <= redir_pc;
            bus.ins_ready <= 1'b0;
            state         <= IDLE;
          end else if (!bus.IFetcher_stall) begin
            fetch_pc      <= bus.predict_nxt_pc;
            bus.ins_ready <= 1'b0;
            state         <= jalr_pend ? BLOCK : IDLE;
          end
        end
        BLOCK: begin
          if (redirect) begin
            fetch_pc <= redir_pc;
            state    <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
